// File: rtl/module_display_mux.sv
// Binary-to-BCD conversion (sequential double dabble) driving a
// 4-digit multiplexed active-low 7-segment display.
module module_display_mux #(
  parameter int REFRESH_DIV = 27000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin_in,
  input  logic        load,
  output logic        busy,
  output logic [15:0] bcd_val,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   sh_q, sh_d;
  logic [15:0]   scr_q, scr_d;
  logic [15:0]   adj;
  logic [3:0]    it_q, it_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction on every scratch nibble before each shift
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM: capture, 14 shift iterations, publish result
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    it_d    = it_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          sh_d    = (bin_in > 14'd9999) ? 14'd9999 : bin_in;
          scr_d   = '0;
          it_d    = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        {scr_d, sh_d} = {adj[14:0], sh_q, 1'b0};
        it_d = it_q + 4'd1;
        if (it_q == 4'd13)
          state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = scr_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running digit scan; segments follow the next index and value
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    nib   = bcd_d[4*idx_d +: 4];
    blank = 1'b0;
    unique case (idx_d)
      2'd1:    blank = (bcd_d[15:4] == 12'd0);
      2'd2:    blank = (bcd_d[15:8] == 8'd0);
      2'd3:    blank = (bcd_d[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    an_d  = ~(4'b0001 << idx_d);
    seg_d = (BLANK_LZ && blank) ? 7'b1111111 : dec7(nib);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      it_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      it_q    <= it_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign bcd_val = bcd_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_module_display_mux.sv
// Bench for module_display_mux: decimal-level model compared every
// cycle, plus directed literal checks of conversions and scan.
module tb_module_display_mux;

  localparam int RD = 4;
  localparam bit BLZ = 1'b1;
  localparam logic [6:0] PAT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin_in;
  logic        load;
  logic        busy;
  logic [15:0] bcd_val;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_n = 0;
  int m_val = 0;
  int m_pend = 0;
  int m_bc = 0;

  module_display_mux #(
    .REFRESH_DIV(RD),
    .BLANK_LZ(BLZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bin_in(bin_in),
    .load(load),
    .busy(busy),
    .bcd_val(bcd_val),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (BLZ && i > 0 && v < p) return 7'b1111111;
    return PAT[(v / p) % 10];
  endfunction

  // Decimal-level model: busy countdown, saturated pending value, scan position
  always @(posedge clk) begin
    if (rst) begin
      m_n  <= 0;
      m_val <= 0;
      m_bc <= 0;
    end else begin
      m_n <= m_n + 1;
      if (m_bc == 0 && load) begin
        m_bc   <= 15;
        m_pend <= (int'(bin_in) > 9999) ? 9999 : int'(bin_in);
      end else if (m_bc > 0) begin
        m_bc <= m_bc - 1;
        if (m_bc == 1) m_val <= m_pend;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      logic [3:0] ea;
      logic [6:0] es;
      idx = (m_n / RD) % 4;
      ea = ~(4'b0001 << idx);
      es = exp_seg(m_val, idx);
      checks++;
      if (busy !== (m_bc != 0)) begin
        errors++;
        $display("FAIL busy t=%0t got %b want %b", $time, busy, m_bc != 0);
      end
      checks++;
      if (bcd_val !== to_bcd(m_val)) begin
        errors++;
        $display("FAIL bcd_val t=%0t got %h want %h",
                 $time, bcd_val, to_bcd(m_val));
      end
      checks++;
      if (an !== ea) begin
        errors++;
        $display("FAIL an t=%0t got %b want %b", $time, an, ea);
      end
      checks++;
      if (seg !== es) begin
        errors++;
        $display("FAIL seg t=%0t got %b want %b", $time, seg, es);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic do_load(input int v);
    bin_in = 14'(v);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Load v, count busy cycles, check result right after edge k+15
  task automatic conv(input int v, input logic [15:0] want, input string nm);
    int nb = 0;
    do_load(v);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (i == 15) chk({nm, "_k15"}, bcd_val, want);
    end
    chk({nm, "_busy_cycles"}, 16'(nb), 16'd15);
  endtask

  task automatic check_digit(input int i, input logic [6:0] want,
                             input string nm);
    bit found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (an == ~(4'b0001 << i)) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_an_timeout got %b want %b", nm, an, ~(4'b0001 << i));
    end else begin
      chk(nm, {9'd0, seg}, {9'd0, want});
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    bin_in = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_an", {12'd0, an}, 16'h000e);
    chk("rst_seg", {9'd0, seg}, {9'd0, 7'b1000000});
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_bcd", bcd_val, 16'h0000);

    conv(1234, 16'h1234, "c1234");
    conv(9801, 16'h9801, "c9801");
    check_digit(0, 7'b1111001, "d9801_0");
    check_digit(1, 7'b1000000, "d9801_1");
    check_digit(2, 7'b0000000, "d9801_2");
    check_digit(3, 7'b0010000, "d9801_3");
    conv(12000, 16'h9999, "c12000");
    conv(16383, 16'h9999, "c16383");
    conv(0, 16'h0000, "c0");
    check_digit(0, 7'b1000000, "d0_0");
    check_digit(1, 7'b1111111, "d0_1");
    conv(7, 16'h0007, "c7");
    check_digit(0, 7'b1111000, "d7_0");
    check_digit(1, 7'b1111111, "d7_1");
    check_digit(2, 7'b1111111, "d7_2");
    check_digit(3, 7'b1111111, "d7_3");
    conv(9999, 16'h9999, "c9999");
    conv(50, 16'h0050, "c50");
    check_digit(0, 7'b1000000, "d50_0");
    check_digit(1, 7'b0010010, "d50_1");
    check_digit(2, 7'b1111111, "d50_2");

    do_load(1234);
    for (int i = 0; i < 4; i++) step();
    bin_in = 14'd5678;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("ignored_load", bcd_val, 16'h1234);

    do_load(4321);
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_bcd", bcd_val, 16'h0000);
    for (int i = 0; i < 20; i++) step();
    chk("abort_bcd_later", bcd_val, 16'h0000);

    conv(808, 16'h0808, "c808");
    rst = 1'b1;
    bin_in = 14'd55;
    load = 1'b1;
    step();
    rst = 1'b0;
    load = 1'b0;
    @(negedge clk);
    chk("rst_wins_busy", {15'd0, busy}, 16'd0);
    chk("rst_wins_bcd", bcd_val, 16'h0000);
    for (int i = 0; i < 20; i++) step();
    chk("rst_wins_later", bcd_val, 16'h0000);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
